pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central stall/flush/halt sequencer for the 5-stage 32-bit pipeline (IF, OF, EX, MA, RW).
- Drives the per-stage register enables for pc, pr1 (IF/OF), pr2 (OF/EX), pr3 (EX/MA) and pr4 (MA/RW), and the bubble/flush controls.
- Resolves load-use hazards, taken branches from EX (beq/bgt/ubranch/call/ret), multi-cycle data-memory accesses in MA, and a drain-then-halt sequence.
- Keeps saturating stall and flush performance counters.

Parameters:
REG_AW, 4, register-address width (16 architectural registers)
MEM_TIMEOUT, 64, max cycles waiting for ma_ready before error
DRAIN_CYCLES, 3, cycles needed to empty EX/MA/RW after a halt
CNT_W, 16, width of performance counters

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous active-high reset
of_rs1  in  REG_AW  OF-stage source 1
of_rs1_vld  in  1  OF instruction reads rs1
of_rs2  in  REG_AW  OF-stage source 2
of_rs2_vld  in  1  OF instruction reads rs2
ex_rd  in  REG_AW  EX-stage destination
ex_isld  in  1  EX instruction is a load
ex_iswb  in  1  EX instruction writes back
ex_br_taken  in  1  EX resolved a taken control transfer
ma_req  in  1  MA instruction is ld or st
ma_ready  in  1  data memory completes the MA access this cycle
halt_req  in  1  OF decoded hlt (level)
pc_en, pr1_en, pr2_en, pr3_en, pr4_en  out  1 each  register load enables
pr2_bubble  out  1  load NOP into pr2
flush  out  1  load NOP into pr1 and pr2 (wrong-path kill)
halted  out  1  pipeline stopped after halt
mem_err  out  1  sticky memory timeout
state  out  3  FSM state, debug
stall_cnt  out  CNT_W  saturating stall-cycle count
flush_cnt  out  CNT_W  saturating flush count

Behaviour:
- States: RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3, ERR=4. On rst: state=RUN, counters=0, timer=0, halt_pend=0, halted=0, mem_err=0.
- Enables, bubble and flush are combinational from state and inputs, zero-latency. Counters, timer and flags are registered.
- RUN decision order; first matching rule wins:
  1. ma_req & !ma_ready -> all enables 0, no bubble, no flush; next=MEM_WAIT; timer=1.
  2. ex_br_taken -> all enables 1, flush=1; flush_cnt+1. A load-use hit in the same cycle is ignored because the OF instruction is wrong-path.
  3. Load-use: ex_isld & ex_iswb & ((of_rs1_vld & of_rs1==ex_rd) | (of_rs2_vld & of_rs2==ex_rd)) -> pc_en=pr1_en=0, pr2_en=1, pr2_bubble=1, pr3_en=pr4_en=1; stall_cnt+1. The next cycle re-evaluates, and the bubble in EX clears the hit.
  4. halt_req | halt_pend -> pc_en=pr1_en=0, pr2_en=1, pr2_bubble=1, pr3_en=pr4_en=1; next=DRAIN; timer=1.
  5. Otherwise all enables 1.
- MEM_WAIT:
  - All enables 0 until ma_ready.
  - The ma_ready cycle: all enables 1, next=RUN. A taken branch held in EX is acted on in that same cycle (flush=1).
  - Timer increments each waiting cycle. Timer==MEM_TIMEOUT with !ma_ready -> next=ERR, mem_err=1.
  - stall_cnt+1 each cycle without ma_ready.
  - halt_req seen here sets halt_pend.
- DRAIN:
  - pc_en=pr1_en=0, pr2_bubble=1, pr2_en=pr3_en=pr4_en=1.
  - ma_req & !ma_ready freezes everything and holds the timer, with no stall count. The timeout rule applies as in MEM_WAIT.
  - Timer==DRAIN_CYCLES -> next=HALTED. No other rules apply in DRAIN.
- HALTED: all enables 0, halted=1. Exit only by rst.
- ERR: all enables 0, mem_err=1. Exit only by rst.
- Counters saturate at all-ones and never wrap. No counting in HALTED or ERR.
- Asserting rst mid-operation aborts any wait or drain immediately and clears everything asynchronously.

Decomposition:
- Shared package pipe_pkg holds:
  - state encodings
  - REG_AW
  - NOP instruction constant, used by the pr-register bubble muxes
- Sub-module sat_counter (CNT_W, inc, async rst), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Load-use: ex_isld=1, ex_iswb=1, ex_rd=5, of_rs1=5, of_rs1_vld=1 -> one cycle pc_en=pr1_en=0 and pr2_bubble=1, then full flow; stall_cnt=1.
- Branch plus hazard together: ex_br_taken=1 with the load-use hit -> flush=1, all enables 1, flush_cnt=1, stall_cnt=0.
- Memory wait: ma_req=1 with ma_ready low for 4 cycles, then high -> enables 0 for 4 cycles, 1 on the ready cycle; stall_cnt=4; state 1 then 0.
- Timeout: ma_req=1 and ma_ready=0 for 64 cycles -> state=ERR, mem_err=1; enables stay 0 until rst.
- Halt: halt_req pulse in RUN -> 1 bubble cycle plus 3 DRAIN cycles, then halted=1, state=3. A halt_req arriving during MEM_WAIT takes effect after ready.
- Reset: rst asserted mid-DRAIN and mid-MEM_WAIT -> state=0, counters=0, halted=0, mem_err=0 with no clock edge needed. Saturation: force 65535 stalls -> stall_cnt holds 0xFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the 5-stage pipeline control logic.
//   - REG_AW      : architectural register-address width (16 registers)
//   - NOP_INSTR   : instruction word loaded into pr1/pr2 by the bubble/flush muxes
//   - state_e     : sequencer state encoding (also exported on the debug port)
//   - ctrl_t      : bundle of register enables plus bubble/flush controls
package pipe_pkg;

    localparam int REG_AW = 4;

    // SimpleRisc nop: opcode 5'b01101 in bits [31:27], all other fields zero.
    localparam logic [31:0] NOP_INSTR = 32'h6800_0000;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_HALTED   = 3'd3,
        ST_ERR      = 3'd4
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic pr1_en;
        logic pr2_en;
        logic pr3_en;
        logic pr4_en;
        logic pr2_bubble;
        logic flush;
    } ctrl_t;

    // Common control patterns.
    localparam ctrl_t CTRL_HOLD   = 7'b00000_00;  // whole pipe frozen
    localparam ctrl_t CTRL_FLOW   = 7'b11111_00;  // everything advances
    localparam ctrl_t CTRL_BUBBLE = 7'b00111_10;  // IF/OF held, NOP into EX, back end drains
    localparam ctrl_t CTRL_FLUSH  = 7'b11111_01;  // advance and kill wrong-path IF/OF

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter: saturating up-counter used for pipeline performance statistics.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, clears the count
//   inc : add one this cycle (ignored once the count is all-ones)
//   cnt : current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/halt sequencer for the IF-OF-EX-MA-RW pipeline.
//   Inputs : OF source registers, EX destination/load/writeback/branch info,
//            MA memory request/ready handshake, halt request from OF decode.
//   Outputs: pc/pr1..pr4 load enables, pr2 bubble, IF/OF flush (combinational),
//            halted and sticky mem_err flags, debug state, and saturating
//            stall/flush cycle counters.
module pipeline_ctrl #(
    parameter int REG_AW       = pipe_pkg::REG_AW,
    parameter int MEM_TIMEOUT  = 64,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] of_rs1,
    input  logic              of_rs1_vld,
    input  logic [REG_AW-1:0] of_rs2,
    input  logic              of_rs2_vld,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_isld,
    input  logic              ex_iswb,
    input  logic              ex_br_taken,
    input  logic              ma_req,
    input  logic              ma_ready,
    input  logic              halt_req,
    output logic              pc_en,
    output logic              pr1_en,
    output logic              pr2_en,
    output logic              pr3_en,
    output logic              pr4_en,
    output logic              pr2_bubble,
    output logic              flush,
    output logic              halted,
    output logic              mem_err,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    import pipe_pkg::*;

    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(MEM_TIMEOUT);
    localparam logic [DRN_W-1:0] DRN_LIMIT = DRN_W'(DRAIN_CYCLES);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;     // cycles spent waiting on the current MA access
    logic [DRN_W-1:0] drain_q, drain_d;     // drain progress, 1 on entry to DRAIN
    logic             halt_pend_q, halt_pend_d;
    logic             halted_q, halted_d;
    logic             mem_err_q, mem_err_d;
    logic             stall_inc, flush_inc;
    ctrl_t            ctrl;

    logic load_use;
    logic mem_stall;
    logic timed_out;

    assign load_use  = ex_isld && ex_iswb &&
                       ((of_rs1_vld && (of_rs1 == ex_rd)) ||
                        (of_rs2_vld && (of_rs2 == ex_rd)));
    assign mem_stall = ma_req && !ma_ready;
    assign timed_out = (timer_q == TMR_LIMIT);

    always_comb begin
        ctrl        = CTRL_HOLD;
        state_d     = state_q;
        timer_d     = timer_q;
        drain_d     = drain_q;
        halt_pend_d = halt_pend_q;
        halted_d    = halted_q;
        mem_err_d   = mem_err_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d   = ST_MEM_WAIT;
                    timer_d   = TMR_W'(1);
                    stall_inc = 1'b1;
                end else if (ex_br_taken) begin
                    // OF holds a wrong-path instruction, so any load-use hit is moot.
                    ctrl      = CTRL_FLUSH;
                    flush_inc = 1'b1;
                end else if (load_use) begin
                    ctrl      = CTRL_BUBBLE;
                    stall_inc = 1'b1;
                end else if (halt_req || halt_pend_q) begin
                    ctrl        = CTRL_BUBBLE;
                    state_d     = ST_DRAIN;
                    drain_d     = DRN_W'(1);
                    halt_pend_d = 1'b0;
                end else begin
                    ctrl = CTRL_FLOW;
                end
            end

            ST_MEM_WAIT: begin
                if (halt_req) begin
                    halt_pend_d = 1'b1;
                end
                if (ma_ready) begin
                    // A taken branch waiting in EX resolves on the release cycle.
                    ctrl       = CTRL_FLOW;
                    ctrl.flush = ex_br_taken;
                    flush_inc  = ex_br_taken;
                    state_d    = ST_RUN;
                    timer_d    = '0;
                end else begin
                    stall_inc = 1'b1;
                    if (timed_out) begin
                        state_d   = ST_ERR;
                        mem_err_d = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end

            ST_DRAIN: begin
                if (mem_stall) begin
                    // Drain progress is frozen; only the memory timer advances.
                    if (timed_out) begin
                        state_d   = ST_ERR;
                        mem_err_d = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end else begin
                    ctrl    = CTRL_BUBBLE;
                    timer_d = '0;
                    if (drain_q == DRN_LIMIT) begin
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        drain_d = drain_q + DRN_W'(1);
                    end
                end
            end

            ST_HALTED: begin
                ctrl = CTRL_HOLD;
            end

            ST_ERR: begin
                ctrl = CTRL_HOLD;
            end

            default: begin
                // Unused encodings fall into the safe, sticky error state.
                state_d   = ST_ERR;
                mem_err_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            timer_q     <= '0;
            drain_q     <= '0;
            halt_pend_q <= 1'b0;
            halted_q    <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            drain_q     <= drain_d;
            halt_pend_q <= halt_pend_d;
            halted_q    <= halted_d;
            mem_err_q   <= mem_err_d;
        end
    end

    // Index 0 counts stall cycles, index 1 counts flushes.
    logic [1:0]            cnt_inc;
    logic [1:0][CNT_W-1:0] cnt_val;

    assign cnt_inc = {flush_inc, stall_inc};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk (clk),
                .rst (rst),
                .inc (cnt_inc[gi]),
                .cnt (cnt_val[gi])
            );
        end
    endgenerate

    assign pc_en      = ctrl.pc_en;
    assign pr1_en     = ctrl.pr1_en;
    assign pr2_en     = ctrl.pr2_en;
    assign pr3_en     = ctrl.pr3_en;
    assign pr4_en     = ctrl.pr4_en;
    assign pr2_bubble = ctrl.pr2_bubble;
    assign flush      = ctrl.flush;
    assign halted     = halted_q;
    assign mem_err    = mem_err_q;
    assign state      = state_q;
    assign stall_cnt  = cnt_val[0];
    assign flush_cnt  = cnt_val[1];

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenarios plus randomized traffic for pipeline_ctrl,
// checked against a cycle-level reference model kept in this bench.
module tb_pipeline_ctrl;

    localparam int REG_AW       = 4;
    localparam int MEM_TIMEOUT  = 64;
    localparam int DRAIN_CYCLES = 3;
    localparam int CNT_W        = 16;
    localparam int CNT_MAX      = 65535;

    // {pc_en, pr1_en, pr2_en, pr3_en, pr4_en, pr2_bubble, flush}
    localparam logic [6:0] C_HOLD  = 7'b0000000;
    localparam logic [6:0] C_FLOW  = 7'b1111100;
    localparam logic [6:0] C_BUB   = 7'b0011110;
    localparam logic [6:0] C_FLUSH = 7'b1111101;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [REG_AW-1:0] of_rs1, of_rs2, ex_rd;
    logic              of_rs1_vld, of_rs2_vld, ex_isld, ex_iswb, ex_br_taken;
    logic              ma_req, ma_ready, halt_req;
    logic              pc_en, pr1_en, pr2_en, pr3_en, pr4_en, pr2_bubble, flush;
    logic              halted, mem_err;
    logic [2:0]        state;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    pipeline_ctrl #(
        .REG_AW       (REG_AW),
        .MEM_TIMEOUT  (MEM_TIMEOUT),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .of_rs1      (of_rs1),
        .of_rs1_vld  (of_rs1_vld),
        .of_rs2      (of_rs2),
        .of_rs2_vld  (of_rs2_vld),
        .ex_rd       (ex_rd),
        .ex_isld     (ex_isld),
        .ex_iswb     (ex_iswb),
        .ex_br_taken (ex_br_taken),
        .ma_req      (ma_req),
        .ma_ready    (ma_ready),
        .halt_req    (halt_req),
        .pc_en       (pc_en),
        .pr1_en      (pr1_en),
        .pr2_en      (pr2_en),
        .pr3_en      (pr3_en),
        .pr4_en      (pr4_en),
        .pr2_bubble  (pr2_bubble),
        .flush       (flush),
        .halted      (halted),
        .mem_err     (mem_err),
        .state       (state),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    wire [6:0] act_ctrl = {pc_en, pr1_en, pr2_en, pr3_en, pr4_en, pr2_bubble, flush};

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: mode uses the externally visible state numbers;
    // missed = consecutive cycles the current MA access has gone unserved;
    // drain_left = drain cycles still owed before the pipe is empty.
    int         m_mode, m_missed, m_drain_left, m_stalls, m_flushes;
    bit         m_pend, m_halted, m_err;
    int         x_mode, x_missed, x_drain_left, x_stalls, x_flushes;
    bit         x_pend, x_halted, x_err;
    logic [6:0] exp_ctrl;

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? v : v + 1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_missed = 0; m_drain_left = 0; m_stalls = 0; m_flushes = 0;
        m_pend = 0; m_halted = 0; m_err = 0;
    endtask

    task automatic model_eval();
        bit hit, miss;
        hit  = ex_isld && ex_iswb && ((of_rs1_vld && of_rs1 == ex_rd) || (of_rs2_vld && of_rs2 == ex_rd));
        miss = ma_req && !ma_ready;
        x_mode = m_mode; x_missed = m_missed; x_drain_left = m_drain_left;
        x_stalls = m_stalls; x_flushes = m_flushes; x_pend = m_pend; x_halted = m_halted; x_err = m_err;
        exp_ctrl = C_HOLD;
        case (m_mode)
            0: begin
                if (miss) begin
                    x_mode = 1; x_missed = 1; x_stalls = sat(m_stalls);
                end else if (ex_br_taken) begin
                    exp_ctrl = C_FLUSH; x_flushes = sat(m_flushes);
                end else if (hit) begin
                    exp_ctrl = C_BUB; x_stalls = sat(m_stalls);
                end else if (halt_req || m_pend) begin
                    exp_ctrl = C_BUB; x_mode = 2; x_drain_left = DRAIN_CYCLES; x_pend = 0;
                end else begin
                    exp_ctrl = C_FLOW;
                end
            end
            1: begin
                if (halt_req) x_pend = 1;
                if (ma_ready) begin
                    exp_ctrl = ex_br_taken ? C_FLUSH : C_FLOW;
                    if (ex_br_taken) x_flushes = sat(m_flushes);
                    x_mode = 0; x_missed = 0;
                end else begin
                    x_stalls = sat(m_stalls);
                    if (m_missed + 1 > MEM_TIMEOUT) begin x_mode = 4; x_err = 1; end
                    else x_missed = m_missed + 1;
                end
            end
            2: begin
                if (miss) begin
                    if (m_missed + 1 > MEM_TIMEOUT) begin x_mode = 4; x_err = 1; end
                    else x_missed = m_missed + 1;
                end else begin
                    exp_ctrl = C_BUB; x_missed = 0;
                    if (m_drain_left == 1) begin x_mode = 3; x_halted = 1; end
                    else x_drain_left = m_drain_left - 1;
                end
            end
            default: exp_ctrl = C_HOLD;
        endcase
    endtask

    // One clock: evaluate the model on the current inputs, take the edge, commit.
    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
        m_mode = x_mode; m_missed = x_missed; m_drain_left = x_drain_left;
        m_stalls = x_stalls; m_flushes = x_flushes; m_pend = x_pend; m_halted = x_halted; m_err = x_err;
    endtask

    task automatic idle();
        of_rs1 = '0; of_rs2 = '0; ex_rd = '0; of_rs1_vld = 0; of_rs2_vld = 0;
        ex_isld = 0; ex_iswb = 0; ex_br_taken = 0; ma_req = 0; ma_ready = 0; halt_req = 0;
    endtask

    // Raise rst between clock edges; the bench then observes the async clear.
    task automatic assert_rst();
        rst = 0; #1; rst = 1; #1;
        model_reset();
    endtask

    task automatic release_rst();
        idle();
        rst = 0;
        tick();
    endtask

    task automatic set_load_use(input logic [REG_AW-1:0] r);
        ex_isld = 1; ex_iswb = 1; ex_rd = r; of_rs1 = r; of_rs1_vld = 1;
    endtask

    task automatic test_reset();
        idle();
        assert_rst();
        n_checks++; if (state !== 3'd0 || halted !== 1'b0 || mem_err !== 1'b0) begin n_fails++;
            $display("FAIL reset_flags: got state=%0d halted=%b mem_err=%b required 0/0/0", state, halted, mem_err); end
        n_checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_fails++;
            $display("FAIL reset_cnt: got stall=%0d flush=%0d required 0/0", stall_cnt, flush_cnt); end
        release_rst();
        n_checks++; if (act_ctrl !== C_FLOW) begin n_fails++;
            $display("FAIL reset_idle_ctrl: got %b required %b", act_ctrl, C_FLOW); end
    endtask

    task automatic test_load_use();
        assert_rst(); release_rst();
        set_load_use(4'd5); #2;
        n_checks++; if (act_ctrl !== C_BUB) begin n_fails++;
            $display("FAIL lu_rs1_ctrl: got %b required %b", act_ctrl, C_BUB); end
        tick();
        n_checks++; if (stall_cnt !== 16'd1) begin n_fails++;
            $display("FAIL lu_stall_cnt: got %0d required 1", stall_cnt); end
        idle(); #2;
        n_checks++; if (act_ctrl !== C_FLOW || state !== 3'd0) begin n_fails++;
            $display("FAIL lu_resume: got ctrl=%b state=%0d required %b/0", act_ctrl, state, C_FLOW); end
        tick();
        ex_isld = 1; ex_iswb = 1; ex_rd = 4'd9; of_rs1 = 4'd9; of_rs2 = 4'd9; of_rs2_vld = 1; #2;
        n_checks++; if (act_ctrl !== C_BUB) begin n_fails++;
            $display("FAIL lu_rs2_ctrl: got %b required %b", act_ctrl, C_BUB); end
        tick();
        ex_iswb = 0; #2;
        n_checks++; if (act_ctrl !== C_FLOW) begin n_fails++;
            $display("FAIL lu_no_wb_ctrl: got %b required %b", act_ctrl, C_FLOW); end
        tick();
        ex_iswb = 1; of_rs2_vld = 0; #2;
        n_checks++; if (act_ctrl !== C_FLOW) begin n_fails++;
            $display("FAIL lu_no_vld_ctrl: got %b required %b", act_ctrl, C_FLOW); end
        tick();
        n_checks++; if (stall_cnt !== 16'd2) begin n_fails++;
            $display("FAIL lu_stall_total: got %0d required 2", stall_cnt); end
        idle();
    endtask

    task automatic test_branch_hazard();
        assert_rst(); release_rst();
        set_load_use(4'd7); ex_br_taken = 1; #2;
        n_checks++; if (act_ctrl !== C_FLUSH) begin n_fails++;
            $display("FAIL br_lu_ctrl: got %b required %b", act_ctrl, C_FLUSH); end
        tick();
        n_checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin n_fails++;
            $display("FAIL br_lu_cnt: got flush=%0d stall=%0d required 1/0", flush_cnt, stall_cnt); end
        idle();
    endtask

    task automatic test_mem_wait();
        assert_rst(); release_rst();
        ma_req = 1; ma_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #2;
            n_checks++; if (act_ctrl !== C_HOLD) begin n_fails++;
                $display("FAIL mw_hold_ctrl[%0d]: got %b required %b", i, act_ctrl, C_HOLD); end
            tick();
            n_checks++; if (state !== 3'd1) begin n_fails++;
                $display("FAIL mw_state[%0d]: got %0d required 1", i, state); end
        end
        ma_ready = 1; #2;
        n_checks++; if (act_ctrl !== C_FLOW) begin n_fails++;
            $display("FAIL mw_ready_ctrl: got %b required %b", act_ctrl, C_FLOW); end
        tick();
        n_checks++; if (state !== 3'd0 || stall_cnt !== 16'd4) begin n_fails++;
            $display("FAIL mw_done: got state=%0d stall=%0d required 0/4", state, stall_cnt); end
        // Taken branch held in EX acts on the ready cycle.
        ma_ready = 0; tick();
        ma_ready = 1; ex_br_taken = 1; #2;
        n_checks++; if (act_ctrl !== C_FLUSH) begin n_fails++;
            $display("FAIL mw_branch_ctrl: got %b required %b", act_ctrl, C_FLUSH); end
        tick();
        n_checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd5) begin n_fails++;
            $display("FAIL mw_branch_cnt: got flush=%0d stall=%0d required 1/5", flush_cnt, stall_cnt); end
        // Halt seen while waiting takes effect once the access completes.
        ex_br_taken = 0; ma_ready = 0; tick();
        halt_req = 1; tick();
        halt_req = 0; ma_ready = 1; #2;
        n_checks++; if (act_ctrl !== C_FLOW) begin n_fails++;
            $display("FAIL mw_halt_ready_ctrl: got %b required %b", act_ctrl, C_FLOW); end
        tick();
        idle(); #2;
        n_checks++; if (act_ctrl !== C_BUB || state !== 3'd0) begin n_fails++;
            $display("FAIL mw_halt_pend: got ctrl=%b state=%0d required %b/0", act_ctrl, state, C_BUB); end
        tick();
        for (int i = 0; i < DRAIN_CYCLES; i++) tick();
        n_checks++; if (state !== 3'd3 || halted !== 1'b1) begin n_fails++;
            $display("FAIL mw_halt_done: got state=%0d halted=%b required 3/1", state, halted); end
    endtask

    task automatic test_timeout();
        int cyc;
        assert_rst(); release_rst();
        ma_req = 1; ma_ready = 0; cyc = 0;
        while (state !== 3'd4 && cyc < 200) begin tick(); cyc++; end
        // The RUN cycle that sees the miss, then MEM_TIMEOUT cycles in MEM_WAIT.
        n_checks++; if (cyc != MEM_TIMEOUT + 1) begin n_fails++;
            $display("FAIL to_cycles: got %0d required %0d", cyc, MEM_TIMEOUT + 1); end
        n_checks++; if (mem_err !== 1'b1 || stall_cnt !== 16'(MEM_TIMEOUT + 1)) begin n_fails++;
            $display("FAIL to_flags: got mem_err=%b stall=%0d required 1/%0d", mem_err, stall_cnt, MEM_TIMEOUT + 1); end
        ma_ready = 1; ex_br_taken = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_checks++; if (act_ctrl !== C_HOLD || state !== 3'd4) begin n_fails++;
                $display("FAIL to_sticky[%0d]: got ctrl=%b state=%0d required %b/4", i, act_ctrl, state, C_HOLD); end
            tick();
        end
        n_checks++; if (flush_cnt !== 16'd0 || stall_cnt !== 16'(MEM_TIMEOUT + 1)) begin n_fails++;
            $display("FAIL to_no_count: got flush=%0d stall=%0d", flush_cnt, stall_cnt); end
        assert_rst();
        n_checks++; if (mem_err !== 1'b0 || state !== 3'd0 || stall_cnt !== 16'd0) begin n_fails++;
            $display("FAIL to_reset: got mem_err=%b state=%0d stall=%0d required 0/0/0", mem_err, state, stall_cnt); end
        release_rst();
    endtask

    task automatic test_halt();
        assert_rst(); release_rst();
        halt_req = 1; #2;
        n_checks++; if (act_ctrl !== C_BUB) begin n_fails++;
            $display("FAIL halt_bubble: got %b required %b", act_ctrl, C_BUB); end
        tick();
        halt_req = 0;
        for (int i = 0; i < DRAIN_CYCLES; i++) begin
            #2;
            n_checks++; if (act_ctrl !== C_BUB || state !== 3'd2) begin n_fails++;
                $display("FAIL halt_drain[%0d]: got ctrl=%b state=%0d required %b/2", i, act_ctrl, state, C_BUB); end
            tick();
        end
        ex_br_taken = 1; #2;
        n_checks++; if (state !== 3'd3 || halted !== 1'b1 || act_ctrl !== C_HOLD) begin n_fails++;
            $display("FAIL halt_final: got state=%0d halted=%b ctrl=%b required 3/1/%b", state, halted, act_ctrl, C_HOLD); end
        tick();
        n_checks++; if (flush_cnt !== 16'd0 || stall_cnt !== 16'd0) begin n_fails++;
            $display("FAIL halt_no_count: got flush=%0d stall=%0d required 0/0", flush_cnt, stall_cnt); end
        // A memory stall during drain freezes the drain without counting stalls.
        assert_rst(); release_rst();
        halt_req = 1; tick();
        halt_req = 0; tick();
        ma_req = 1; ma_ready = 0;
        for (int i = 0; i < 2; i++) begin
            #2;
            n_checks++; if (act_ctrl !== C_HOLD) begin n_fails++;
                $display("FAIL drain_freeze[%0d]: got %b required %b", i, act_ctrl, C_HOLD); end
            tick();
        end
        ma_req = 0;
        tick();
        n_checks++; if (state !== 3'd2) begin n_fails++;
            $display("FAIL drain_resume: got state=%0d required 2", state); end
        tick();
        n_checks++; if (state !== 3'd3 || stall_cnt !== 16'd0) begin n_fails++;
            $display("FAIL drain_freeze_done: got state=%0d stall=%0d required 3/0", state, stall_cnt); end
    endtask

    task automatic test_reset_mid();
        assert_rst(); release_rst();
        set_load_use(4'd3); tick();
        idle(); halt_req = 1; tick();
        halt_req = 0; tick();
        assert_rst();
        n_checks++; if (state !== 3'd0 || stall_cnt !== 16'd0 || halted !== 1'b0 || mem_err !== 1'b0) begin n_fails++;
            $display("FAIL rst_mid_drain: got state=%0d stall=%0d halted=%b mem_err=%b", state, stall_cnt, halted, mem_err); end
        release_rst();
        ma_req = 1; ma_ready = 0; tick(); tick();
        assert_rst();
        n_checks++; if (state !== 3'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_fails++;
            $display("FAIL rst_mid_wait: got state=%0d stall=%0d flush=%0d", state, stall_cnt, flush_cnt); end
        release_rst();
        n_checks++; if (act_ctrl !== C_FLOW || state !== 3'd0) begin n_fails++;
            $display("FAIL rst_mid_after: got ctrl=%b state=%0d", act_ctrl, state); end
    endtask

    task automatic test_random();
        for (int ep = 0; ep < 30; ep++) begin
            assert_rst(); release_rst();
            for (int c = 0; c < 40; c++) begin
                of_rs1 = 4'($urandom_range(0, 3)); of_rs2 = 4'($urandom_range(0, 3));
                ex_rd = 4'($urandom_range(0, 3));
                of_rs1_vld = 1'($urandom_range(0, 1)); of_rs2_vld = 1'($urandom_range(0, 1));
                ex_isld = 1'($urandom_range(0, 1)); ex_iswb = ($urandom_range(0, 3) != 0);
                ex_br_taken = ($urandom_range(0, 7) == 0);
                ma_req = ($urandom_range(0, 2) == 0); ma_ready = 1'($urandom_range(0, 1));
                halt_req = ($urandom_range(0, 19) == 0);
                #2;
                model_eval();
                n_checks++; if (act_ctrl !== exp_ctrl) begin n_fails++;
                    $display("FAIL rnd_ctrl ep%0d c%0d: got %b required %b", ep, c, act_ctrl, exp_ctrl); end
                n_checks++; if (state !== 3'(m_mode)) begin n_fails++;
                    $display("FAIL rnd_state ep%0d c%0d: got %0d required %0d", ep, c, state, m_mode); end
                n_checks++; if (halted !== m_halted || mem_err !== m_err) begin n_fails++;
                    $display("FAIL rnd_flags ep%0d c%0d: got %b%b required %b%b", ep, c, halted, mem_err, m_halted, m_err); end
                n_checks++; if (stall_cnt !== 16'(m_stalls) || flush_cnt !== 16'(m_flushes)) begin n_fails++;
                    $display("FAIL rnd_cnt ep%0d c%0d: got %0d/%0d required %0d/%0d", ep, c, stall_cnt, flush_cnt, m_stalls, m_flushes); end
                tick();
            end
        end
        idle();
    endtask

    task automatic test_saturation();
        assert_rst(); release_rst();
        set_load_use(4'd2);
        for (int i = 0; i < CNT_MAX - 1; i++) tick();
        n_checks++; if (stall_cnt !== 16'hFFFE) begin n_fails++;
            $display("FAIL sat_below: got %h required fffe", stall_cnt); end
        tick();
        n_checks++; if (stall_cnt !== 16'hFFFF) begin n_fails++;
            $display("FAIL sat_reach: got %h required ffff", stall_cnt); end
        for (int i = 0; i < 4; i++) tick();
        #2;
        n_checks++; if (stall_cnt !== 16'hFFFF || stall_cnt !== 16'(m_stalls) || act_ctrl !== C_BUB) begin n_fails++;
            $display("FAIL sat_hold: got cnt=%h ctrl=%b required ffff/%b", stall_cnt, act_ctrl, C_BUB); end
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_load_use();
        test_branch_hazard();
        test_mem_wait();
        test_timeout();
        test_halt();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
